led_matrix_scan_ctrl: RTL and testbench

LED_MATRIX_SCAN_CTRL -- requirements
Module: led_matrix_scan_ctrl

---
 rtl/led_matrix_scan_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_ctrl
//
// Purpose:
//   Column-scan controller for a 5-column x 7-row LED matrix. Each column is
//   preceded by BLANK_CYC all-off cycles (ghosting suppression) and then
//   driven for SCAN_DIV cycles with the row pattern latched from the image
//   mux. After HOLD_FRAMES complete frames the image select alternates
//   between the water-level image (0) and the irrigation-status image (1),
//   unless force_level pins the display to image 0.
//
// Parameters:
//   SCAN_DIV    : cycles each column is driven            (1..255)
//   BLANK_CYC   : all-off cycles before each column drive  (1..255)
//   HOLD_FRAMES : frames each image is shown before toggle (1..255)
//
// Ports:
//   clk         in   1  : single clock, rising edge
//   rst_n       in   1  : synchronous active-low reset
//   enable      in   1  : 1 = scan, 0 = matrix off (returns to IDLE)
//   rows_status in  35  : row bits for the selected image, column k at [7k+6:7k]
//   force_level in   1  : 1 = pin display to image 0 (sampled at frame end)
//   img_sel     out  1  : image select to the external mux
//   col_n       out  5  : active-low column drive, at most one bit low
//   row_out     out  7  : active-high row drive
//   frame_done  out  1  : one-cycle pulse after column 4 finishes its drive
//
// All outputs come straight from registers; no input reaches an output
// without passing through a flop.
// -----------------------------------------------------------------------------
module led_matrix_scan_ctrl #(
    parameter int unsigned SCAN_DIV    = 4,
    parameter int unsigned BLANK_CYC   = 1,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [34:0] rows_status,
    input  logic        force_level,
    output logic        img_sel,
    output logic [4:0]  col_n,
    output logic [6:0]  row_out,
    output logic        frame_done
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    // One phase counter serves both BLANK and DRIVE, so it is sized for the
    // longer of the two. The +1 keeps the width non-zero when a parameter is 1.
    localparam int unsigned PH_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned FC_W   = $clog2(HOLD_FRAMES + 1);

    localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_CYC - 1);
    localparam logic [PH_W-1:0] DRIVE_LAST = PH_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(HOLD_FRAMES - 1);
    localparam logic [2:0]      COL_LAST   = 3'd4;
    localparam int unsigned     NUM_COLS   = 5;

    localparam logic [4:0] COLS_OFF = 5'b11111;
    localparam logic [6:0] ROWS_OFF = 7'b0000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t          r_state;
    logic [2:0]      r_col_idx;
    logic [PH_W-1:0] r_phase;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_img_sel;
    logic [4:0]      r_col_n;
    logic [6:0]      r_row_out;
    logic            r_frame_done;

    // Next-state values
    state_t          w_state_next;
    logic [2:0]      w_col_idx_next;
    logic [PH_W-1:0] w_phase_next;
    logic [FC_W-1:0] w_frame_cnt_next;
    logic            w_img_sel_next;
    logic [4:0]      w_col_n_next;
    logic [6:0]      w_row_out_next;
    logic            w_frame_done_next;

    // -------------------------------------------------------------------------
    // Column unpacking and column-select decode
    // -------------------------------------------------------------------------
    logic [6:0] w_col_rows [NUM_COLS];
    logic [4:0] w_col_sel_n;

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_unpack
            assign w_col_rows[gi] = rows_status[7*gi +: 7];
        end
    endgenerate

    // Active-low one-hot for the current column
    assign w_col_sel_n = ~(5'b00001 << r_col_idx);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_col_idx_next    = r_col_idx;
        w_phase_next      = r_phase;
        w_frame_cnt_next  = r_frame_cnt;
        w_img_sel_next    = r_img_sel;
        w_col_n_next      = r_col_n;
        w_row_out_next    = r_row_out;
        w_frame_done_next = 1'b0;

        if (!enable) begin
            // Matrix off from any state; the image select is kept so the
            // display resumes on the same image.
            w_state_next     = S_IDLE;
            w_col_idx_next   = 3'd0;
            w_phase_next     = '0;
            w_frame_cnt_next = '0;
            w_col_n_next     = COLS_OFF;
            w_row_out_next   = ROWS_OFF;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_next   = S_BLANK;
                    w_col_idx_next = 3'd0;
                    w_phase_next   = '0;
                    w_col_n_next   = COLS_OFF;
                    w_row_out_next = ROWS_OFF;
                end

                S_BLANK: begin
                    if (r_phase == BLANK_LAST) begin
                        // Rows are captured here, at least one cycle after
                        // any img_sel change, so the mux output is settled.
                        w_state_next   = S_DRIVE;
                        w_phase_next   = '0;
                        w_row_out_next = w_col_rows[r_col_idx];
                        w_col_n_next   = w_col_sel_n;
                    end else begin
                        w_phase_next = r_phase + PH_W'(1);
                    end
                end

                S_DRIVE: begin
                    if (r_phase == DRIVE_LAST) begin
                        w_state_next   = S_BLANK;
                        w_phase_next   = '0;
                        w_col_n_next   = COLS_OFF;
                        w_row_out_next = ROWS_OFF;
                        if (r_col_idx == COL_LAST) begin
                            // End of frame: the only point where the image
                            // select and the frame counter may move.
                            w_col_idx_next    = 3'd0;
                            w_frame_done_next = 1'b1;
                            if (force_level) begin
                                w_img_sel_next   = 1'b0;
                                w_frame_cnt_next = '0;
                            end else if (r_frame_cnt == FRAME_LAST) begin
                                w_img_sel_next   = ~r_img_sel;
                                w_frame_cnt_next = '0;
                            end else begin
                                w_frame_cnt_next = r_frame_cnt + FC_W'(1);
                            end
                        end else begin
                            w_col_idx_next = r_col_idx + 3'd1;
                        end
                    end else begin
                        w_phase_next = r_phase + PH_W'(1);
                    end
                end

                default: begin
                    w_state_next     = S_IDLE;
                    w_col_idx_next   = 3'd0;
                    w_phase_next     = '0;
                    w_frame_cnt_next = '0;
                    w_col_n_next     = COLS_OFF;
                    w_row_out_next   = ROWS_OFF;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col_idx    <= 3'd0;
            r_phase      <= '0;
            r_frame_cnt  <= '0;
            r_img_sel    <= 1'b0;
            r_col_n      <= COLS_OFF;
            r_row_out    <= ROWS_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_col_idx    <= w_col_idx_next;
            r_phase      <= w_phase_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_img_sel    <= w_img_sel_next;
            r_col_n      <= w_col_n_next;
            r_row_out    <= w_row_out_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign img_sel    = r_img_sel;
    assign col_n      = r_col_n;
    assign row_out    = r_row_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
module tb_led_matrix_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [34:0] rows_status;
    logic        force_level;
    logic        img_sel;
    logic [4:0]  col_n;
    logic [6:0]  row_out;
    logic        frame_done;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    led_matrix_scan_ctrl #(
        .SCAN_DIV    (4),
        .BLANK_CYC   (1),
        .HOLD_FRAMES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rows_status (rows_status),
        .force_level (force_level),
        .img_sel     (img_sel),
        .col_n       (col_n),
        .row_out     (row_out),
        .frame_done  (frame_done)
    );

    // Column k carries 7'b0000001 << k
    localparam logic [34:0] ROWS = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       force_l;
        logic [4:0] exp_col;
        logic [6:0] exp_row;
        logic       exp_fd;
        logic       exp_img;
    } vec_t;

    vec_t vecs [28];
    int   nv = 0;

    task automatic add_vec(input logic r, input logic e, input logic f,
                           input logic [4:0] c, input logic [6:0] rw,
                           input logic fd, input logic im);
        vecs[nv].rst_n   = r;
        vecs[nv].en      = e;
        vecs[nv].force_l = f;
        vecs[nv].exp_col = c;
        vecs[nv].exp_row = rw;
        vecs[nv].exp_fd  = fd;
        vecs[nv].exp_img = im;
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance until frame_done is seen (bounded). Reports cycles taken and
    // how many times img_sel moved on a non-frame_done cycle.
    task automatic wait_fd(output int cycles, output int changes);
        logic prev;
        cycles  = -1;
        changes = 0;
        prev    = img_sel;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                cycles = c;
                break;
            end
            if (img_sel !== prev) changes++;
            prev = img_sel;
        end
    endtask

    task automatic check_outs(input string name, input logic [4:0] c, input logic [6:0] r,
                              input logic fd, input logic im);
        check({name, "_col"}, 32'(col_n), 32'(c));
        check({name, "_row"}, 32'(row_out), 32'(r));
        check({name, "_fd"},  32'(frame_done), 32'(fd));
        check({name, "_img"}, 32'(img_sel), 32'(im));
    endtask

    initial begin
        int gap;
        int chg;
        logic [6:0] rbit;

        rst_n       = 1'b0;
        enable      = 1'b0;
        force_level = 1'b0;
        rows_status = ROWS;

        // Reset with enable high, release, then one full frame
        add_vec(1'b0, 1'b1, 1'b0, 5'b11111, 7'h00, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 5'b11111, 7'h00, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 5'b11111, 7'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            rbit = 7'b0000001 << k;
            for (int d = 0; d < 4; d++)
                add_vec(1'b1, 1'b1, 1'b0, ~(5'b00001 << k), rbit, 1'b0, 1'b0);
            add_vec(1'b1, 1'b1, 1'b0, 5'b11111, 7'h00, (k == 4), 1'b0);
        end

        @(negedge clk);
        for (int i = 0; i < nv; i++) begin
            rst_n       = vecs[i].rst_n;
            enable      = vecs[i].en;
            force_level = vecs[i].force_l;
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_col, vecs[i].exp_row,
                       vecs[i].exp_fd, vecs[i].exp_img);
            $display("vec %0d col_n=%b row_out=%b fd=%b img=%b",
                     i, col_n, row_out, frame_done, img_sel);
        end

        // frame_done is a single-cycle pulse
        @(negedge clk);
        check("fd_single", 32'(frame_done), 32'd0);
        check("fd_next_col", 32'(col_n), 32'b11110);

        // Free-running alternation: pulse 1 already seen above
        for (int p = 2; p <= 24; p++) begin
            wait_fd(gap, chg);
            check($sformatf("alt_gap%0d", p), 32'(gap), (p == 2) ? 32'd24 : 32'd25);
            check($sformatf("alt_stable%0d", p), 32'(chg), 32'd0);
            check($sformatf("alt_img%0d", p), 32'(img_sel), 32'((p / 8) % 2));
            $display("frame_done #%0d gap=%0d img_sel=%b", p, gap, img_sel);
        end

        // Force raised mid-frame while img_sel=1
        repeat (10) @(negedge clk);
        force_level = 1'b1;
        wait_fd(gap, chg);
        check("force_gap", 32'(gap), 32'd15);
        check("force_stable", 32'(chg), 32'd0);
        check("force_img", 32'(img_sel), 32'd0);
        $display("forced frame_done img_sel=%b", img_sel);
        for (int s = 0; s < 2; s++) begin
            wait_fd(gap, chg);
            check($sformatf("forced_img%0d", s), 32'(img_sel), 32'd0);
            $display("forced hold frame_done img_sel=%b", img_sel);
        end
        repeat (5) @(negedge clk);
        force_level = 1'b0;

        // After release, 8th frame_done toggles; a short force glitch that
        // ends before a frame boundary must have no effect.
        for (int s = 1; s <= 8; s++) begin
            wait_fd(gap, chg);
            check($sformatf("rel_img%0d", s), 32'(img_sel), (s == 8) ? 32'd1 : 32'd0);
            check($sformatf("rel_stable%0d", s), 32'(chg), 32'd0);
            $display("release frame_done #%0d img_sel=%b", s, img_sel);
            if (s == 3) begin
                repeat (6) @(negedge clk);
                force_level = 1'b1;
                repeat (3) @(negedge clk);
                force_level = 1'b0;
            end
        end

        // Disable during column 2 drive
        repeat (11) @(negedge clk);
        check("dis_col2_col", 32'(col_n), 32'b11011);
        check("dis_col2_row", 32'(row_out), 32'b0000100);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_outs("dis_off", 5'b11111, 7'h00, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("dis_hold", 5'b11111, 7'h00, 1'b0, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        check_outs("reen_blank", 5'b11111, 7'h00, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("reen_col0", 5'b11110, 7'b0000001, 1'b0, 1'b1);
        $display("disable/re-enable col_n=%b img_sel=%b", col_n, img_sel);

        // Mid-frame reset during column 3 drive with img_sel=1
        repeat (15) @(negedge clk);
        check("rst_col3_col", 32'(col_n), 32'b10111);
        check("rst_col3_row", 32'(row_out), 32'b0001000);
        rst_n = 1'b0;
        @(negedge clk);
        check_outs("midrst", 5'b11111, 7'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("midrst_blank", 5'b11111, 7'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("midrst_col0", 5'b11110, 7'b0000001, 1'b0, 1'b0);
        $display("mid-frame reset col_n=%b img_sel=%b", col_n, img_sel);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
